tiny_riscv_periph_ctrl: RTL and testbench

Memory-mapped peripheral controller on the processor data bus. It decodes the one-hot peripheral word address, holds the LED and 7-segment registers, and buffers UART bytes in a TX FIFO. A drain sequencer feeds those bytes to the UART emitter over a valid/ready handshake. It also returns status words to the processor.

---
 rtl/tiny_riscv_periph_pkg.sv | 21 ++
 rtl/tiny_riscv_sync_fifo.sv | 53 +++++
 rtl/tiny_riscv_periph_ctrl.sv | 138 +++++++++++++
 tb/tb_tiny_riscv_periph_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tiny_riscv_periph_pkg.sv
// Shared constants for the memory-mapped peripheral controller.
// Address bit indices, status bit positions and drain states.
package tiny_riscv_periph_pkg;

  localparam int A_LED       = 0;
  localparam int A_UART_DATA = 1;
  localparam int A_UART_CTRL = 2;
  localparam int A_SEG1      = 3;
  localparam int A_SEG2      = 4;

  localparam int ST_OVF       = 8;
  localparam int ST_BUSY      = 9;
  localparam int ST_IDLE      = 10;
  localparam int ST_COUNT_LSB = 16;

  typedef enum logic {
    IDLE,
    PRESENT
  } drain_state_t;

endpackage

// File: rtl/tiny_riscv_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module tiny_riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tiny_riscv_periph_ctrl.sv
// Peripheral controller: LED/7-seg registers, UART TX FIFO,
// drain sequencer to the UART emitter and status read-back.
module tiny_riscv_periph_ctrl
  import tiny_riscv_periph_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_periph_sel,
  input  logic [29:0] i_word_addr,
  input  logic        i_write_strobe,
  input  logic [31:0] i_write_data,
  input  logic        i_read_strobe,
  output logic [31:0] o_read_data,
  output logic [7:0]  o_uart_data,
  output logic        o_uart_valid,
  input  logic        i_uart_ready,
  output logic [3:0]  o_LED,
  output logic [6:0]  o_seg1_data,
  output logic [6:0]  o_seg2_data
);

  drain_state_t state;
  drain_state_t state_d;

  logic             wr;
  logic             wr_led;
  logic             wr_data;
  logic             wr_ctrl;
  logic             wr_seg1;
  logic             wr_seg2;
  logic             pop;
  logic             ovf;
  logic             ovf_set;
  logic             ovf_clr;
  logic             full;
  logic             empty;
  logic [7:0]       head;
  logic [CNT_W-1:0] count;
  logic [31:0]      status;
  logic             unused;

  assign wr      = i_periph_sel & i_write_strobe;
  assign wr_led  = wr & i_word_addr[A_LED];
  assign wr_data = wr & i_word_addr[A_UART_DATA];
  assign wr_ctrl = wr & i_word_addr[A_UART_CTRL];
  assign wr_seg1 = wr & i_word_addr[A_SEG1];
  assign wr_seg2 = wr & i_word_addr[A_SEG2];
  assign ovf_set = wr_data & full & ~pop;
  assign ovf_clr = wr_ctrl & i_write_data[0];

  assign unused = ^{i_read_strobe, i_word_addr[29:5], i_write_data[31:8]};

  tiny_riscv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_tx_fifo (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .push      (wr_data),
    .push_data (i_write_data[7:0]),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_LED       <= '0;
      o_seg1_data <= '0;
      o_seg2_data <= '0;
      ovf         <= 1'b0;
    end else begin
      if (wr_led)  o_LED       <= i_write_data[3:0];
      if (wr_seg1) o_seg1_data <= i_write_data[6:0];
      if (wr_seg2) o_seg2_data <= i_write_data[6:0];
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= IDLE;
      o_uart_data <= '0;
    end else begin
      state <= state_d;
      if (pop) o_uart_data <= head;
    end
  end

  // Accepting a byte and loading the next happen on the same edge.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (i_uart_ready) begin
          if (!empty) pop = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_uart_valid = (state == PRESENT);

  always_comb begin
    status                           = '0;
    status[ST_OVF]                   = ovf;
    status[ST_BUSY]                  = full;
    status[ST_IDLE]                  = empty & ~o_uart_valid;
    status[ST_COUNT_LSB +: CNT_W]    = count;
  end

  always_comb begin
    o_read_data = '0;
    if (i_periph_sel) begin
      if (i_word_addr[A_UART_CTRL])  o_read_data = status;
      else if (i_word_addr[A_LED])   o_read_data = {28'h0, o_LED};
      else if (i_word_addr[A_SEG1])  o_read_data = {25'h0, o_seg1_data};
      else if (i_word_addr[A_SEG2])  o_read_data = {25'h0, o_seg2_data};
    end
  end

endmodule

// File: tb/tb_tiny_riscv_periph_ctrl.sv
// Bench for the peripheral controller: register writes, UART drain
// order via a byte scoreboard, overflow, full push/pop, async reset.
module tb_tiny_riscv_periph_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [29:0] addr = '0;
  logic        wstb = 1'b0;
  logic [31:0] wdata = '0;
  logic        rstb = 1'b0;
  logic [31:0] rd;
  logic [7:0]  udata;
  logic        uvalid;
  logic        uready = 1'b0;
  logic [3:0]  led;
  logic [6:0]  seg1;
  logic [6:0]  seg2;

  int asserts = 0;
  int fails   = 0;
  logic [7:0] sbq[$];

  tiny_riscv_periph_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_periph_sel   (sel),
    .i_word_addr    (addr),
    .i_write_strobe (wstb),
    .i_write_data   (wdata),
    .i_read_strobe  (rstb),
    .o_read_data    (rd),
    .o_uart_data    (udata),
    .o_uart_valid   (uvalid),
    .i_uart_ready   (uready),
    .o_LED          (led),
    .o_seg1_data    (seg1),
    .o_seg2_data    (seg2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && uvalid && uready) begin
      if (sbq.size() == 0) check("sb_extra_byte", {24'h0, udata}, 32'hFFFF_FFFF);
      else check("sb_byte", {24'h0, udata}, {24'h0, sbq.pop_front()});
    end
  end

  task automatic bus_wr(input logic [29:0] a, input logic [31:0] d,
                        input logic s);
    sel = s; addr = a; wstb = 1'b1; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; addr = '0; wstb = 1'b0; wdata = '0;
  endtask

  task automatic tx(input logic [7:0] b, input bit keep);
    if (keep) sbq.push_back(b);
    bus_wr(30'h2, {24'h0, b}, 1'b1);
  endtask

  task automatic rd_chk(input string tag, input logic [29:0] a,
                        input logic [31:0] exp);
    sel = 1'b1; addr = a; rstb = 1'b1;
    #1;
    check(tag, rd, exp);
    sel = 1'b0; addr = '0; rstb = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0 && !uvalid) break;
      @(posedge clk); #1;
    end
    check("drain_done", {31'h0, (sbq.size() == 0 && !uvalid)}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_led", {28'h0, led}, 32'h0);
    check("rst_valid", {31'h0, uvalid}, 32'h0);
    check("rst_udata", {24'h0, udata}, 32'h0);
    rd_chk("rst_ctrl", 30'h4, 32'h0000_0400);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    bus_wr(30'h1, 32'hA, 1'b1);
    check("led_wr", {28'h0, led}, 32'hA);
    check("led_seg1", {25'h0, seg1}, 32'h0);
    check("led_seg2", {25'h0, seg2}, 32'h0);
    check("led_valid", {31'h0, uvalid}, 32'h0);

    uready = 1'b1;
    tx(8'h48, 1'b1);
    tx(8'h69, 1'b1);
    check("hi_lat_valid", {31'h0, uvalid}, 32'h1);
    check("hi_first", {24'h0, udata}, 32'h48);
    @(posedge clk); #1;
    check("hi_second", {24'h0, udata}, 32'h69);
    check("hi_second_valid", {31'h0, uvalid}, 32'h1);
    @(posedge clk); #1;
    check("hi_done_valid", {31'h0, uvalid}, 32'h0);
    rd_chk("hi_ctrl", 30'h4, 32'h0000_0400);

    uready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      tx(8'h20 + 8'(i), i < DEPTH + 1);
      if (i == DEPTH - 1) rd_chk("ovf_pre_full", 30'h4, 32'h000F_0000);
      if (i == DEPTH)     rd_chk("ovf_full", 30'h4, 32'h0010_0200);
    end
    rd_chk("ovf_set", 30'h4, 32'h0010_0300);
    uready = 1'b1;
    drain();
    rd_chk("ovf_sticky", 30'h4, 32'h0000_0500);
    bus_wr(30'h4, 32'h1, 1'b1);
    rd_chk("ovf_clear", 30'h4, 32'h0000_0400);

    uready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) tx(8'h40 + 8'(i), 1'b1);
    uready = 1'b1;
    tx(8'h60, 1'b1);
    uready = 1'b0;
    rd_chk("full_pushpop", 30'h4, 32'h0010_0200);
    uready = 1'b1;
    drain();

    uready = 1'b0;
    for (int i = 0; i < 4; i++) tx(8'h50 + 8'(i), 1'b1);
    rd_chk("pre_rst_ctrl", 30'h4, 32'h0003_0000);
    check("pre_rst_valid", {31'h0, uvalid}, 32'h1);
    #1 rst = 1'b1;
    sbq.delete();
    #1;
    check("arst_valid", {31'h0, uvalid}, 32'h0);
    rd_chk("arst_ctrl", 30'h4, 32'h0000_0400);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("post_rst_ctrl", 30'h4, 32'h0000_0400);
    check("post_rst_led", {28'h0, led}, 32'h0);

    bus_wr(30'h19, 32'h7F, 1'b1);
    check("multi_led", {28'h0, led}, 32'hF);
    check("multi_seg1", {25'h0, seg1}, 32'h7F);
    check("multi_seg2", {25'h0, seg2}, 32'h7F);
    rd_chk("rd_prio_led", 30'h9, 32'hF);
    rd_chk("rd_seg1", 30'h18, 32'h7F);
    rd_chk("rd_uart_data", 30'h2, 32'h0);
    sel = 1'b0; addr = 30'h1;
    #1;
    check("rd_nosel", rd, 32'h0);
    addr = '0;
    bus_wr(30'h1, 32'h3, 1'b0);
    check("wr_nosel", {28'h0, led}, 32'hF);
    rd_chk("final_ctrl", 30'h4, 32'h0000_0400);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
